cache_ctrl_assoc: RTL and testbench
===================================

Name: cache_ctrl_assoc

Overview:
- Parametrised set-associative, write-back, write-allocate L1 cache controller. Successor to the direct-mapped write-through controller.
- Holds tag, valid, dirty and data arrays internally. Serves one CPU request at a time over a req/ready handshake.
- Moves whole blocks to and from main memory over a req/ack handshake.

Parameters:
- DATA_WIDTH, 32: bits per word.
- ADDR_WIDTH, 10: CPU word-address width.
- WAYS, 2: associativity, ≥1.
- SETS, 16: number of sets, power of 2.
- WORDS_PER_BLOCK, 4: words per line, power of 2.
- Derived: OFF_BITS=clog2(WORDS_PER_BLOCK), IDX_BITS=clog2(SETS), TAG_BITS=ADDR_WIDTH-IDX_BITS-OFF_BITS, BLK_W=DATA_WIDTH*WORDS_PER_BLOCK.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_WIDTH  word address, split {tag,index,offset}.
- cpu_wdata  in  DATA_WIDTH  write data.
- cpu_rdata  out  DATA_WIDTH  read data; valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high when state≠IDLE.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1=block writeback, 0=block fetch.
- mem_addr  out  ADDR_WIDTH-OFF_BITS  block address {tag,index}.
- mem_wdata  out  BLK_W  block being written back; word 0 in LSBs.
- mem_rdata  in  BLK_W  fetched block; word 0 in LSBs.
- mem_ack  in  1  one-cycle; completes the current mem_req.

Behaviour:
- Reset (async, while reset_n=0):
  - Every valid bit, dirty bit and per-set round-robin pointer clears to 0; state=IDLE.
  - cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_we, mem_addr and mem_wdata are all 0.
  - Data and tag arrays need no reset.
  - Reset mid-transaction drops mem_req in the same instant. The in-flight request is abandoned; no cpu_ready is issued. Dirty data is lost.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND.
- IDLE:
  - If cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, then go to COMPARE.
  - cpu_req while busy is ignored; the CPU must hold or re-issue it.
- COMPARE:
  - Hit = any way of set[index] with valid=1 and tag match.
  - Read hit: the selected word is registered into cpu_rdata. Go to RESPOND.
  - Write hit: update the word, set dirty=1. Go to RESPOND.
  - Miss: pick the victim way as the lowest-numbered invalid way; if none is invalid, use rr_ptr[index].
  - Miss with victim valid and dirty: go to WRITEBACK. Otherwise go to ALLOCATE.
- RESPOND: cpu_ready=1 for exactly one cycle, then IDLE.
- Hit latency: cpu_ready is high in the 2nd cycle after the IDLE edge that sampled cpu_req.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim block.
  - These values stay stable until the mem_ack cycle; then go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr={req tag,index}.
  - On mem_ack: write mem_rdata into the victim way, set tag, valid=1, dirty=0.
  - If the victim was chosen by rr_ptr, rr_ptr[index] increments mod WAYS.
  - Return to COMPARE, which then hits. A write miss therefore ends with dirty=1.
- Memory handshake:
  - mem_req deasserts in the cycle after mem_ack.
  - mem_ack while mem_req=0 is ignored.
  - Unbounded ack latency is legal; cpu_busy stays 1 throughout.
- Reads never modify dirty bits.
- Hit and miss alike return in-order single-word data.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined:
  - Adds 32-bit outputs hit_count, miss_count and wb_count.
  - hit_count increments on each COMPARE with hit=1 that was not entered from ALLOCATE.
  - miss_count increments on each COMPARE with hit=0.
  - wb_count increments on each WRITEBACK mem_ack.
  - All three reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Defaults (TAG 4b, IDX 4b, OFF 2b), after reset. Read 0x045 → mem_req/mem_we=0, mem_addr=0x11. Ack with block words {0xA0,0xA1,0xA2,0xA3} → cpu_rdata=0xA1 with cpu_ready. Then read 0x046 → cpu_rdata=0xA2, ready 2 cycles after sampling, no mem_req.
- Write 0x045=0xDEADBEEF (hit) → no mem traffic, cpu_ready pulse. Read 0x045 → 0xDEADBEEF.
- Set 1 sequence: read 0x004 (way0), write 0x044=0x1234 (way1, dirty), read 0x084 → victim way0, clean, no writeback. Read 0x0C4 → WRITEBACK with mem_addr=0x11 and word0=0x1234, then ALLOCATE with mem_addr=0x31.
- Hold mem_ack low 10 cycles during ALLOCATE → mem_req, mem_addr stable; cpu_ready=0; cpu_busy=1. Ack → completes normally.
- Drop reset_n mid-ALLOCATE → mem_req=0 and cpu_busy=0 immediately. After release, read of the same address misses again.
- With CACHE_STATS_EN, run the third scenario from reset → hit_count=0, miss_count=4, wb_count=1.

Source files
------------

// File: rtl/cache_ctrl_assoc.sv
// Set-associative, write-back, write-allocate L1 cache controller with block-granular memory port.
// Optional hit/miss/writeback statistics counters are enabled by defining CACHE_STATS_EN.
module cache_ctrl_assoc #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned WAYS            = 2,
    parameter int unsigned SETS            = 16,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              cpu_req,
    input  logic                                              cpu_we,
    input  logic [ADDR_WIDTH-1:0]                             cpu_addr,
    input  logic [DATA_WIDTH-1:0]                             cpu_wdata,
    output logic [DATA_WIDTH-1:0]                             cpu_rdata,
    output logic                                              cpu_ready,
    output logic                                              cpu_busy,
    output logic                                              mem_req,
    output logic                                              mem_we,
    output logic [ADDR_WIDTH-$clog2(WORDS_PER_BLOCK)-1:0]     mem_addr,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0]             mem_wdata,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0]             mem_rdata,
    input  logic                                              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                                       hit_count,
    output logic [31:0]                                       miss_count,
    output logic [31:0]                                       wb_count
`endif
);

    localparam int unsigned OFF_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned TAG_BITS = ADDR_WIDTH - IDX_BITS - OFF_BITS;
    localparam int unsigned BLK_W    = DATA_WIDTH * WORDS_PER_BLOCK;
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        RESPOND
    } state_t;

    state_t state_q, state_d;

    logic                  req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;

    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [BLK_W-1:0]    data_q  [SETS][WAYS];
    logic                valid_q [SETS][WAYS];
    logic                dirty_q [SETS][WAYS];
    logic [WAY_W-1:0]    rr_q    [SETS];

    logic [WAY_W-1:0] victim_q;
    logic             victim_rr_q;

    logic [TAG_BITS-1:0]   req_tag_c;
    logic [IDX_BITS-1:0]   req_idx_c;
    logic [OFF_BITS-1:0]   req_off_c;
    logic                  hit_c;
    logic [WAY_W-1:0]      hit_way_c;
    logic [WAY_W-1:0]      vic_way_c;
    logic                  vic_rr_c;
    logic                  vic_dirty_c;
    logic [BLK_W-1:0]      hit_blk_c;
    logic [BLK_W-1:0]      wr_blk_c;
    logic [DATA_WIDTH-1:0] hit_word_c;
    logic                  ready_d;
    logic                  busy_d;
    logic                  mem_req_d;

    assign req_tag_c = req_addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_idx_c = req_addr_q[OFF_BITS +: IDX_BITS];
    assign req_off_c = req_addr_q[OFF_BITS-1:0];

    // Tag lookup and victim choice: lowest invalid way, otherwise the set's round-robin pointer
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        vic_way_c = rr_q[req_idx_c];
        vic_rr_c  = 1'b1;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx_c][w] && (tag_q[req_idx_c][w] == req_tag_c) && !hit_c) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_q[req_idx_c][w] && vic_rr_c) begin
                vic_way_c = WAY_W'(w);
                vic_rr_c  = 1'b0;
            end
        end
    end

    assign vic_dirty_c = valid_q[req_idx_c][vic_way_c] && dirty_q[req_idx_c][vic_way_c];
    assign hit_blk_c   = data_q[req_idx_c][hit_way_c];

    // Word select for read hits and word merge for write hits
    always_comb begin
        hit_word_c = '0;
        wr_blk_c   = hit_blk_c;
        for (int unsigned i = 0; i < WORDS_PER_BLOCK; i++) begin
            if (req_off_c == OFF_BITS'(i)) begin
                hit_word_c                          = hit_blk_c[i*DATA_WIDTH +: DATA_WIDTH];
                wr_blk_c[i*DATA_WIDTH +: DATA_WIDTH] = req_wdata_q;
            end
        end
    end

    // Next-state and next-cycle registered strobes
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        case (state_q)
            IDLE:      if (cpu_req) state_d = COMPARE;
            COMPARE: begin
                if (hit_c)            state_d = RESPOND;
                else if (vic_dirty_c) state_d = WRITEBACK;
                else                  state_d = ALLOCATE;
            end
            WRITEBACK: if (mem_ack) state_d = ALLOCATE;
            ALLOCATE:  if (mem_ack) state_d = COMPARE;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        ready_d   = (state_d == RESPOND);
        busy_d    = (state_d != IDLE);
        mem_req_d = (state_d == WRITEBACK) || (state_d == ALLOCATE);
    end

    // State, control outputs and per-line status bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cpu_rdata   <= '0;
            cpu_ready   <= 1'b0;
            cpu_busy    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q   <= state_d;
            cpu_ready <= ready_d;
            cpu_busy  <= busy_d;
            mem_req   <= mem_req_d;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        req_we_q    <= cpu_we;
                        req_addr_q  <= cpu_addr;
                        req_wdata_q <= cpu_wdata;
                    end
                end
                COMPARE: begin
                    if (hit_c) begin
                        if (req_we_q) dirty_q[req_idx_c][hit_way_c] <= 1'b1;
                        else          cpu_rdata <= hit_word_c;
                    end else begin
                        victim_q    <= vic_way_c;
                        victim_rr_q <= vic_rr_c;
                        if (vic_dirty_c) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_q[req_idx_c][vic_way_c], req_idx_c};
                            mem_wdata <= data_q[req_idx_c][vic_way_c];
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= req_addr_q[ADDR_WIDTH-1:OFF_BITS];
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= req_addr_q[ADDR_WIDTH-1:OFF_BITS];
                    end
                end
                ALLOCATE: begin
                    if (mem_ack) begin
                        valid_q[req_idx_c][victim_q] <= 1'b1;
                        dirty_q[req_idx_c][victim_q] <= 1'b0;
                        if (victim_rr_q) begin
                            rr_q[req_idx_c] <= (rr_q[req_idx_c] == WAY_W'(WAYS - 1)) ?
                                               '0 : rr_q[req_idx_c] + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if ((state_q == COMPARE) && hit_c && req_we_q) begin
            data_q[req_idx_c][hit_way_c] <= wr_blk_c;
        end
        if ((state_q == ALLOCATE) && mem_ack) begin
            data_q[req_idx_c][victim_q] <= mem_rdata;
            tag_q[req_idx_c][victim_q]  <= req_tag_c;
        end
    end

`ifdef CACHE_STATS_EN
    logic from_alloc_q;

    // Saturating counters; the re-compare after a fill is not counted as a hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count    <= '0;
            miss_count   <= '0;
            wb_count     <= '0;
            from_alloc_q <= 1'b0;
        end else begin
            if (state_q == ALLOCATE && mem_ack) from_alloc_q <= 1'b1;
            else if (state_q == COMPARE)       from_alloc_q <= 1'b0;
            if (state_q == COMPARE) begin
                if (hit_c && !from_alloc_q && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
                if (!hit_c && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
            end
            if ((state_q == WRITEBACK) && mem_ack && (wb_count != 32'hFFFF_FFFF)) begin
                wb_count <= wb_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Bench for cache_ctrl_assoc: directed scenarios then random traffic against a flat golden memory
// plus a set/way occupancy model that predicts hits, victims and memory traffic.
module tb_cache_ctrl_assoc;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         cpu_busy;
    logic         mem_req;
    logic         mem_we;
    logic [7:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count, miss_count, wb_count;
`endif

    cache_ctrl_assoc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_busy  (cpu_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count),
        .wb_count  (wb_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mainmem [1024];
    logic [31:0] gold    [1024];
    bit          m_valid [16][2];
    bit          m_dirty [16][2];
    int          m_tag   [16][2];
    int          m_rr    [16];

    logic [31:0]  last_rdata;
    logic [7:0]   last_wb_addr;
    logic [127:0] last_wb_blk;
    logic [7:0]   last_fetch_addr;
    int           last_ntx;
    int           last_cyc;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Forget cached state: memory-side contents become the architectural view
    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = 0;
            end
        end
        for (int i = 0; i < 1024; i++) gold[i] = mainmem[i];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_busy", cpu_busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        model_reset();
        reset_n = 1'b1;
    endtask

    // One CPU transaction, acting as main memory with 'delay' wait cycles per block transfer
    task automatic access(input bit we, input logic [9:0] addr, input logic [31:0] wd, input int delay);
        int set, tag, vic, hw, ntx, wait_cnt, cyc, exp_ntx, b;
        bit hit, used_rr, exp_wb, done;
        logic [7:0]   exp_wb_addr, exp_fetch, cur_addr;
        logic [127:0] exp_wb_blk;
        logic [31:0]  exp_rd;
        logic         cur_we;

        set = int'(addr[5:2]);
        tag = int'(addr[9:6]);
        hit = 1'b0;
        hw  = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[set][w] && m_tag[set][w] == tag && !hit) begin hit = 1'b1; hw = w; end
        exp_rd      = gold[addr];
        exp_fetch   = addr[9:2];
        exp_wb      = 1'b0;
        exp_wb_addr = '0;
        exp_wb_blk  = '0;
        if (!hit) begin
            vic = -1;
            for (int w = 0; w < 2; w++) if (!m_valid[set][w] && vic < 0) vic = w;
            used_rr = (vic < 0);
            if (used_rr) vic = m_rr[set];
            exp_wb = m_valid[set][vic] && m_dirty[set][vic];
            if (exp_wb) begin
                exp_wb_addr = 8'(m_tag[set][vic] * 16 + set);
                b = int'(exp_wb_addr) * 4;
                exp_wb_blk = {gold[b+3], gold[b+2], gold[b+1], gold[b]};
            end
            m_valid[set][vic] = 1'b1;
            m_dirty[set][vic] = 1'b0;
            m_tag[set][vic]   = tag;
            if (used_rr) m_rr[set] = (m_rr[set] + 1) % 2;
            hw = vic;
        end
        if (we) begin
            m_dirty[set][hw] = 1'b1;
            gold[addr] = wd;
        end
        exp_ntx = hit ? 0 : (exp_wb ? 2 : 1);

        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(negedge clk);
        cpu_req  = 1'b0;
        cyc      = 1;
        ntx      = 0;
        wait_cnt = 0;
        done     = 1'b0;
        cur_addr = '0;
        cur_we   = 1'b0;
        while (!done && cyc < 200) begin
            mem_ack = 1'b0;
            if (cpu_ready) begin
                done = 1'b1;
            end else if (mem_req) begin
                chk("busy_during_mem", cpu_busy, 1);
                if (wait_cnt == 0) begin
                    cur_addr = mem_addr;
                    cur_we   = mem_we;
                    if (ntx == 0 && exp_wb) begin
                        chk("wb_we", mem_we, 1);
                        chk("wb_addr", mem_addr, exp_wb_addr);
                        chk("wb_data", mem_wdata, exp_wb_blk);
                        last_wb_addr = mem_addr;
                        last_wb_blk  = mem_wdata;
                    end else begin
                        chk("fetch_we", mem_we, 0);
                        chk("fetch_addr", mem_addr, exp_fetch);
                        last_fetch_addr = mem_addr;
                    end
                end else begin
                    chk("stall_addr_stable", mem_addr, cur_addr);
                    chk("stall_we_stable", mem_we, cur_we);
                end
                if (wait_cnt >= delay) begin
                    b = int'(mem_addr) * 4;
                    if (mem_we) begin
                        for (int i = 0; i < 4; i++) mainmem[b+i] = mem_wdata[i*32 +: 32];
                    end else begin
                        mem_rdata = {mainmem[b+3], mainmem[b+2], mainmem[b+1], mainmem[b]};
                    end
                    mem_ack  = 1'b1;
                    ntx++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        chk("completed", done, 1);
        chk("mem_txn_count", ntx, exp_ntx);
        chk("busy_at_ready", cpu_busy, 1);
        if (hit) chk("hit_latency", cyc, 2);
        if (!we) chk("rdata", cpu_rdata, exp_rd);
        last_rdata = cpu_rdata;
        last_ntx   = ntx;
        last_cyc   = cyc;
        @(negedge clk);
        chk("ready_one_cycle", cpu_ready, 0);
        chk("idle_not_busy", cpu_busy, 0);
    endtask

    initial begin
        int n;
        logic [9:0] ra;
        reset_n   = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 1024; i++) mainmem[i] = $urandom;
        mainmem[10'h044] = 32'hA0;
        mainmem[10'h045] = 32'hA1;
        mainmem[10'h046] = 32'hA2;
        mainmem[10'h047] = 32'hA3;
        #2 reset_n = 1'b0;
        apply_reset();

        // Cold read miss, then a neighbouring-word hit
        access(1'b0, 10'h045, 32'h0, 1);
        chk("s1_fetch_addr", last_fetch_addr, 8'h11);
        chk("s1_rdata", last_rdata, 32'hA1);
        access(1'b0, 10'h046, 32'h0, 0);
        chk("s1_hit_rdata", last_rdata, 32'hA2);
        chk("s1_hit_no_mem", last_ntx, 0);
        chk("s1_hit_cycles", last_cyc, 2);

        // Write hit stays in the cache
        access(1'b1, 10'h045, 32'hDEADBEEF, 0);
        chk("s2_write_no_mem", last_ntx, 0);
        access(1'b0, 10'h045, 32'h0, 0);
        chk("s2_readback", last_rdata, 32'hDEADBEEF);

        // A stray ack while idle must be ignored
        @(negedge clk);
        mem_rdata = {4{32'h5A5A5A5A}};
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_no_busy", cpu_busy, 0);
        access(1'b0, 10'h047, 32'h0, 0);
        chk("stray_ack_rdata", last_rdata, 32'hA3);

        // Set 1 eviction sequence from reset
        apply_reset();
        access(1'b0, 10'h004, 32'h0, 0);
        access(1'b1, 10'h044, 32'h1234, 0);
        access(1'b0, 10'h084, 32'h0, 0);
        chk("s3_clean_victim_one_txn", last_ntx, 1);
        access(1'b0, 10'h0C4, 32'h0, 0);
        chk("s3_wb_addr", last_wb_addr, 8'h11);
        chk("s3_wb_word0", last_wb_blk[31:0], 32'h1234);
        chk("s3_fetch_addr", last_fetch_addr, 8'h31);
        chk("s3_two_txns", last_ntx, 2);
`ifdef CACHE_STATS_EN
        chk("stats_hit", hit_count, 0);
        chk("stats_miss", miss_count, 4);
        chk("stats_wb", wb_count, 1);
`endif

        // Long ack latency during a fill
        access(1'b0, 10'h2A8, 32'h0, 10);
        chk("stall_one_txn", last_ntx, 1);

        // Reset while a fill is outstanding
        apply_reset();
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'h123;
        @(negedge clk);
        cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_req_seen", mem_req, 1);
        repeat (2) @(negedge clk);
        chk("midrst_fetch", mem_we, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_busy", cpu_busy, 0);
        chk("midrst_ready", cpu_ready, 0);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        access(1'b0, 10'h123, 32'h0, 0);
        chk("midrst_misses_again", last_ntx, 1);

        // Random traffic confined to a few sets to force evictions
        for (int i = 0; i < 250; i++) begin
            ra = {4'($urandom), 4'($urandom_range(0, 3)), 2'($urandom)};
            access(1'($urandom), ra, $urandom, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
